// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode constants, latency classes and the latency table for the
// hazard scoreboard.
package hazard_scoreboard_pkg;

    // Base opcodes for RV32 instruction groups
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct7 value that turns an OP instruction into multiply/divide
    localparam logic [6:0] FUNCT7_MD  = 7'b0000001;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MD   = 2'd2
    } lat_class_e;

    typedef struct packed {
        logic       use1;
        logic       use2;
        logic       writes;
        lat_class_e cls;
    } decode_t;

    // Cycles until a result can be consumed. The counters are 4 bits wide,
    // so the unforwarded MD latency is clamped at 15.
    function automatic logic [3:0] latency_of(lat_class_e cls, bit fwd_en, int md_lat);
        int lat;
        case (cls)
            LAT_LOAD: lat = fwd_en ? 1 : 3;
            LAT_MD:   lat = fwd_en ? md_lat : md_lat + 2;
            default:  lat = fwd_en ? 0 : 3;
        endcase
        if (lat > 15) lat = 15;
        return 4'(lat);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request / stall response bundle between the decode stage and the
// hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid_ip;
    logic [6:0]       ID_instr_opcode_ip;
    logic [6:0]       ID_funct7_ip;
    logic [4:0]       ID_src1_addr_ip;
    logic [4:0]       ID_src2_addr_ip;
    logic [4:0]       ID_dest_addr_ip;
    logic             flush_ip;
    logic             stall_op;
    logic [CNT_W-1:0] stall_cycles_op;

    modport master (
        output id_valid_ip, ID_instr_opcode_ip, ID_funct7_ip,
        output ID_src1_addr_ip, ID_src2_addr_ip, ID_dest_addr_ip, flush_ip,
        input  stall_op, stall_cycles_op
    );

    modport slave (
        input  id_valid_ip, ID_instr_opcode_ip, ID_funct7_ip,
        input  ID_src1_addr_ip, ID_src2_addr_ip, ID_dest_addr_ip, flush_ip,
        output stall_op, stall_cycles_op
    );
endinterface

// File: rtl/hazard_decode.sv
// Combinational opcode decode: which sources are read, whether a destination
// is written, and which latency class the result belongs to.
module hazard_decode
    import hazard_scoreboard_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    input  logic [4:0] dest_i,
    output decode_t    dec_o
);

    // Map opcode to register usage; writes to x0 are dropped here
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned and infers a latch.
        dec_o        = '0;
        dec_o.cls    = LAT_ALU;
        case (opcode_i)
            OPC_OP: begin
                dec_o.use1   = 1'b1;
                dec_o.use2   = 1'b1;
                dec_o.writes = 1'b1;
                dec_o.cls    = (funct7_i == FUNCT7_MD) ? LAT_MD : LAT_ALU;
            end
            OPC_STORE, OPC_BRANCH: begin
                dec_o.use1 = 1'b1;
                dec_o.use2 = 1'b1;
            end
            OPC_OPIMM, OPC_JALR: begin
                dec_o.use1   = 1'b1;
                dec_o.writes = 1'b1;
            end
            OPC_LOAD: begin
                dec_o.use1   = 1'b1;
                dec_o.writes = 1'b1;
                dec_o.cls    = LAT_LOAD;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                dec_o.writes = 1'b1;
            end
            default: ;
        endcase
        if (dest_i == 5'd0) dec_o.writes = 1'b0;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register ready counters, multiply/divide
// unit occupancy and a saturating stall counter. Stall is a same-cycle
// decision on the instruction sitting in ID.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int FWD_EN   = 1,
    parameter int MD_LAT   = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    localparam logic [3:0] L_ALU  = latency_of(LAT_ALU,  FWD_EN != 0, MD_LAT);
    localparam logic [3:0] L_LOAD = latency_of(LAT_LOAD, FWD_EN != 0, MD_LAT);
    localparam logic [3:0] L_MD   = latency_of(LAT_MD,   FWD_EN != 0, MD_LAT);
    localparam logic [3:0] MD_OCC = 4'(MD_LAT);

    logic [3:0]       cnt_q [NUM_REGS];
    logic [3:0]       cnt_d [NUM_REGS];
    logic [3:0]       md_busy_q, md_busy_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    decode_t          dec;
    logic [3:0]       dest_lat;
    logic             raw1, raw2, waw, structural;
    logic             stall, issue;
    logic [4:0]       src1, src2, dest;

    assign src1 = bus.ID_src1_addr_ip;
    assign src2 = bus.ID_src2_addr_ip;
    assign dest = bus.ID_dest_addr_ip;

    hazard_decode u_decode (
        .opcode_i (bus.ID_instr_opcode_ip),
        .funct7_i (bus.ID_funct7_ip),
        .dest_i   (dest),
        .dec_o    (dec)
    );

    // Latency the ID instruction would load into its destination counter
    always_comb begin
        case (dec.cls)
            LAT_LOAD: dest_lat = L_LOAD;
            LAT_MD:   dest_lat = L_MD;
            default:  dest_lat = L_ALU;
        endcase
    end

    // Hazard detection and issue qualification for the ID instruction
    always_comb begin
        raw1       = dec.use1 && (src1 != 5'd0) && (cnt_q[src1] != 4'd0);
        raw2       = dec.use2 && (src2 != 5'd0) && (cnt_q[src2] != 4'd0);
        waw        = dec.writes && (cnt_q[dest] > dest_lat);
        structural = (dec.cls == LAT_MD) && (md_busy_q > 4'd1);
        stall      = bus.id_valid_ip && !bus.flush_ip && (raw1 || raw2 || waw || structural);
        issue      = bus.id_valid_ip && !bus.flush_ip && !stall;
    end

    // Next state: age every counter, then let an issuing write override its dest
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != 4'd0) ? cnt_q[r] - 4'd1 : 4'd0;
        end
        if (issue && dec.writes) cnt_d[dest] = dest_lat;

        md_busy_d = (md_busy_q != 4'd0) ? md_busy_q - 4'd1 : 4'd0;
        if (issue && dec.cls == LAT_MD) md_busy_d = MD_OCC;

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State registers; reset empties the scoreboard asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the counter array must be reset, otherwise stale pending bits would stall the first instructions.
            cnt_q       <= '{default: '0};
            md_busy_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            cnt_q       <= cnt_d;
            md_busy_q   <= md_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_op        = stall;
    assign bus.stall_cycles_op = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (with and without bypassing)
// share one ID stream and are checked every cycle against a time-based
// reference model, plus directed latency scenarios.
module tb_hazard_scoreboard;

    localparam int TB_CNT_W = 5;
    localparam int TB_MD    = 8;
    localparam int SAT      = (1 << TB_CNT_W) - 1;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] F7_MD  = 7'b0000001;

    logic clk;
    logic reset;

    // Shared ID stimulus
    logic       v, fl;
    logic [6:0] opc, f7;
    logic [4:0] s1, s2, dd;

    hazard_scoreboard_if #(.CNT_W(TB_CNT_W)) bus0 ();
    hazard_scoreboard_if #(.CNT_W(TB_CNT_W)) bus1 ();

    assign bus0.id_valid_ip = v;            assign bus1.id_valid_ip = v;
    assign bus0.ID_instr_opcode_ip = opc;   assign bus1.ID_instr_opcode_ip = opc;
    assign bus0.ID_funct7_ip = f7;          assign bus1.ID_funct7_ip = f7;
    assign bus0.ID_src1_addr_ip = s1;       assign bus1.ID_src1_addr_ip = s1;
    assign bus0.ID_src2_addr_ip = s2;       assign bus1.ID_src2_addr_ip = s2;
    assign bus0.ID_dest_addr_ip = dd;       assign bus1.ID_dest_addr_ip = dd;
    assign bus0.flush_ip = fl;              assign bus1.flush_ip = fl;

    hazard_scoreboard #(.NUM_REGS(32), .FWD_EN(0), .MD_LAT(TB_MD), .CNT_W(TB_CNT_W)) dut0 (
        .clk (clk), .reset (reset), .bus (bus0.slave)
    );
    hazard_scoreboard #(.NUM_REGS(32), .FWD_EN(1), .MD_LAT(TB_MD), .CNT_W(TB_CNT_W)) dut1 (
        .clk (clk), .reset (reset), .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Reference model: absolute cycle at which each result becomes usable
    int ready_at   [2][32];
    int md_free_at [2];
    int scount     [2];
    int cyc = 0;
    bit obs_stall  [2];

    function automatic int remaining(int at);
        return (at > cyc) ? at - cyc : 0;
    endfunction

    function automatic bit m_writes();
        return (opc inside {OP, OPIMM, LOAD, LUI, AUIPC, JAL, JALR}) && dd != 0;
    endfunction

    function automatic bit m_md();
        return opc == OP && f7 == F7_MD;
    endfunction

    function automatic int m_lat(int f);
        if (m_md())       return f ? TB_MD : ((TB_MD + 2 > 15) ? 15 : TB_MD + 2);
        if (opc == LOAD)  return f ? 1 : 3;
        return f ? 0 : 3;
    endfunction

    function automatic bit model_stall(int f);
        bit u1, u2, haz;
        if (!v || fl) return 1'b0;
        u1  = opc inside {OP, STORE, BRANCH, OPIMM, LOAD, JALR};
        u2  = opc inside {OP, STORE, BRANCH};
        haz = 1'b0;
        if (u1 && s1 != 0 && remaining(ready_at[f][s1]) > 0) haz = 1'b1;
        if (u2 && s2 != 0 && remaining(ready_at[f][s2]) > 0) haz = 1'b1;
        if (m_writes() && remaining(ready_at[f][dd]) > m_lat(f)) haz = 1'b1;
        if (m_md() && remaining(md_free_at[f]) > 1) haz = 1'b1;
        return haz;
    endfunction

    task automatic model_clear();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 32; r++) ready_at[f][r] = 0;
            md_free_at[f] = 0;
            scount[f]     = 0;
        end
    endtask

    task automatic model_edge(input bit st0, input bit st1);
        for (int f = 0; f < 2; f++) begin
            bit st;
            st = f ? st1 : st0;
            if (st) begin
                if (scount[f] < SAT) scount[f]++;
            end else if (v && !fl) begin
                if (m_writes()) ready_at[f][dd] = cyc + m_lat(f) + 1;
                if (m_md())     md_free_at[f]   = cyc + TB_MD + 1;
            end
        end
        cyc++;
    endtask

    // One clock of stimulus; both instances are compared against the model
    task automatic cycle(input bit iv, input logic [6:0] io, input logic [6:0] if7,
                         input logic [4:0] is1, input logic [4:0] is2, input logic [4:0] id,
                         input bit ifl);
        bit exp0, exp1;
        int got0, got1;
        v = iv; opc = io; f7 = if7; s1 = is1; s2 = is2; dd = id; fl = ifl;
        @(negedge clk);
        exp0 = model_stall(0);
        exp1 = model_stall(1);
        obs_stall[0] = bus0.stall_op;
        obs_stall[1] = bus1.stall_op;
        got0 = int'(bus0.stall_cycles_op);
        got1 = int'(bus1.stall_cycles_op);
        assert_cnt += 4;
        if (obs_stall[0] !== exp0) begin
            fail_cnt++;
            $display("FAIL stall_fwd0 cyc %0d: got %0b expected %0b", cyc, obs_stall[0], exp0);
        end
        if (obs_stall[1] !== exp1) begin
            fail_cnt++;
            $display("FAIL stall_fwd1 cyc %0d: got %0b expected %0b", cyc, obs_stall[1], exp1);
        end
        if (got0 !== scount[0]) begin
            fail_cnt++;
            $display("FAIL stall_cycles_fwd0 cyc %0d: got %0d expected %0d", cyc, got0, scount[0]);
        end
        if (got1 !== scount[1]) begin
            fail_cnt++;
            $display("FAIL stall_cycles_fwd1 cyc %0d: got %0d expected %0d", cyc, got1, scount[1]);
        end
        @(posedge clk);
        if (reset) model_edge(exp0, exp1);
        #1;
    endtask

    // Hold one instruction in ID until instance f accepts it; report stalls
    task automatic run_instr(input int f, input logic [6:0] io, input logic [6:0] if7,
                             input logic [4:0] is1, input logic [4:0] is2, input logic [4:0] id,
                             input int max_st, output int stalls);
        stalls = 0;
        forever begin
            cycle(1'b1, io, if7, is1, is2, id, 1'b0);
            if (!obs_stall[f]) break;
            stalls++;
            if (stalls > max_st) begin
                fail_cnt++;
                $display("FAIL issue_timeout fwd%0d: stalled %0d cycles, limit %0d", f, stalls, max_st);
                break;
            end
        end
    endtask

    task automatic drain();
        repeat (20) cycle(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic expect_stalls(input string name, input int got, input int exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d stall cycles expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v = 1'b0; opc = '0; f7 = '0; s1 = '0; s2 = '0; dd = '0; fl = 1'b0;
        #1 reset = 1'b0;
        #1;
        model_clear();
        assert_cnt += 2;
        if (bus1.stall_op !== 1'b0 || bus0.stall_op !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_stall: got %0b/%0b expected 0/0", bus0.stall_op, bus1.stall_op);
        end
        if (bus1.stall_cycles_op !== '0 || bus0.stall_cycles_op !== '0) begin
            fail_cnt++;
            $display("FAIL reset_count: got %0d/%0d expected 0/0", bus0.stall_cycles_op, bus1.stall_cycles_op);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        int n;
        drain();
        run_instr(1, LOAD, 7'd0, 5'd1, 5'd0, 5'd5, 20, n);
        expect_stalls("load_issue", n, 0);
        run_instr(1, OP, 7'd0, 5'd5, 5'd1, 5'd6, 20, n);
        expect_stalls("load_use_fwd1", n, 1);
    endtask

    task automatic test_alu_chain();
        int n;
        drain();
        run_instr(1, OP, 7'd0, 5'd1, 5'd2, 5'd5, 20, n);
        expect_stalls("alu_issue_fwd1", n, 0);
        run_instr(1, OP, 7'd0, 5'd5, 5'd5, 5'd7, 20, n);
        expect_stalls("alu_use_fwd1", n, 0);
        drain();
        run_instr(0, OP, 7'd0, 5'd1, 5'd2, 5'd5, 20, n);
        expect_stalls("alu_issue_fwd0", n, 0);
        run_instr(0, OP, 7'd0, 5'd5, 5'd5, 5'd7, 20, n);
        expect_stalls("alu_use_fwd0", n, 3);
    endtask

    task automatic test_md();
        int n;
        drain();
        run_instr(1, OP, F7_MD, 5'd3, 5'd4, 5'd9, 20, n);
        run_instr(1, OPIMM, 7'd0, 5'd9, 5'd0, 5'd10, 20, n);
        expect_stalls("md_raw", n, 8);
        drain();
        run_instr(1, OP, F7_MD, 5'd3, 5'd4, 5'd9, 20, n);
        run_instr(1, OPIMM, 7'd0, 5'd0, 5'd0, 5'd9, 20, n);
        expect_stalls("md_waw", n, 8);
    endtask

    task automatic test_back_to_back();
        int n;
        drain();
        run_instr(1, OP, F7_MD, 5'd3, 5'd4, 5'd1, 20, n);
        expect_stalls("md_first", n, 0);
        run_instr(1, OP, F7_MD, 5'd3, 5'd4, 5'd2, 20, n);
        expect_stalls("md_structural", n, 7);
        drain();
        run_instr(0, LOAD, 7'd0, 5'd1, 5'd0, 5'd0, 20, n);
        run_instr(0, OP, 7'd0, 5'd0, 5'd0, 5'd3, 20, n);
        expect_stalls("x0_fwd0", n, 0);
        run_instr(1, OP, 7'd0, 5'd1, 5'd2, 5'd0, 20, n);
        run_instr(1, OP, 7'd0, 5'd0, 5'd0, 5'd0, 20, n);
        expect_stalls("x0_fwd1", n, 0);
    endtask

    task automatic test_flush();
        int n;
        drain();
        run_instr(1, LOAD, 7'd0, 5'd1, 5'd0, 5'd5, 20, n);
        cycle(1'b1, OP, 7'd0, 5'd5, 5'd1, 5'd6, 1'b1);
        assert_cnt++;
        if (obs_stall[1] !== 1'b0) begin
            fail_cnt++;
            $display("FAIL flush_stall: got %0b expected 0", obs_stall[1]);
        end
        run_instr(1, OP, 7'd0, 5'd5, 5'd1, 5'd6, 20, n);
        expect_stalls("after_flush_fwd1", n, 0);
        drain();
        run_instr(0, LOAD, 7'd0, 5'd1, 5'd0, 5'd5, 20, n);
        cycle(1'b1, OP, 7'd0, 5'd5, 5'd1, 5'd6, 1'b1);
        run_instr(0, OP, 7'd0, 5'd5, 5'd1, 5'd6, 20, n);
        expect_stalls("after_flush_fwd0", n, 2);
    endtask

    task automatic test_random();
        logic [6:0] tab [10];
        logic [6:0] rf7;
        tab = '{OP, OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, 7'b1111111};
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       rf7 = 7'b0000000;
                1:       rf7 = F7_MD;
                default: rf7 = 7'b0100000;
            endcase
            cycle($urandom_range(0, 9) < 8, tab[$urandom_range(0, 9)], rf7,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drain();
        run_instr(1, OP, F7_MD, 5'd3, 5'd4, 5'd5, 20, n);
        repeat (3) cycle(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        // cnt[x5] is now 5 in the bypassed instance
        v = 1'b1; opc = OPIMM; f7 = 7'd0; s1 = 5'd5; s2 = 5'd0; dd = 5'd6; fl = 1'b0;
        #2;
        assert_cnt++;
        if (bus1.stall_op !== 1'b1) begin
            fail_cnt++;
            $display("FAIL pre_reset_stall: got %0b expected 1", bus1.stall_op);
        end
        reset = 1'b0;
        #1;
        model_clear();
        assert_cnt += 2;
        if (bus1.stall_op !== 1'b0 || bus0.stall_op !== 1'b0) begin
            fail_cnt++;
            $display("FAIL mid_reset_stall: got %0b/%0b expected 0/0", bus0.stall_op, bus1.stall_op);
        end
        if (bus1.stall_cycles_op !== '0 || bus0.stall_cycles_op !== '0) begin
            fail_cnt++;
            $display("FAIL mid_reset_count: got %0d/%0d expected 0/0", bus0.stall_cycles_op, bus1.stall_cycles_op);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(1, OPIMM, 7'd0, 5'd5, 5'd0, 5'd6, 20, n);
        expect_stalls("after_reset", n, 0);
    endtask

    task automatic test_saturate();
        int n;
        drain();
        for (int i = 0; i < 5; i++) begin
            run_instr(1, OP, F7_MD, 5'd3, 5'd4, 5'd9, 20, n);
            run_instr(1, OPIMM, 7'd0, 5'd9, 5'd0, 5'd10, 20, n);
        end
        drain();
        assert_cnt += 2;
        if (int'(bus1.stall_cycles_op) !== SAT) begin
            fail_cnt++;
            $display("FAIL saturate_fwd1: got %0d expected %0d", bus1.stall_cycles_op, SAT);
        end
        if (int'(bus0.stall_cycles_op) !== SAT) begin
            fail_cnt++;
            $display("FAIL saturate_fwd0: got %0d expected %0d", bus0.stall_cycles_op, SAT);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_chain();
        test_md();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
